player_walker: RTL and testbench

Keyboard-driven, tile-locked player movement controller for the overworld renderer. It samples the keyboard `keycode` once per video frame, which is the rising edge of `frame_clk`. A tap turns the player in place. A held key walks the player one tile at a time with sub-tile pixel steps. The block outputs facing direction, pixel position and walk-animation state to the sprite/framebuffer logic.

---
 rtl/player_walker.sv | 235 +++++++++++++++++++++++
 tb/tb_player_walker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_walker.sv
// player_walker: tile-locked keyboard movement controller.
// Samples keycode once per frame (rising edge of frame_clk, seen through Clk)
// and drives facing direction, pixel position and walk-animation state.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous active-high reset
//   frame_clk  in   frame strobe, synchronous to Clk
//   keycode    in   8-bit HID key code
//   blocked    in   tile ahead is impassable (used only with PLAYER_COLLIDE_EN)
//   playerDir  out  facing: 00 up, 01 left, 10 down, 11 right
//   posX/posY  out  pixel position
//   walking    out  high while in WALK
//   step_done  out  one-Clk pulse when a tile step completes
//   walk_frame out  animation phase, toggles per completed step
//
// Build option: define PLAYER_COLLIDE_EN to make `blocked` veto movement.
module player_walker #(
  parameter int          X_W         = 10,
  parameter int          Y_W         = 10,
  parameter int          TILE_PX     = 16,
  parameter int          STEP_PX     = 2,
  parameter int          TURN_FRAMES = 4,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 304,
  parameter int          Y_MIN       = 0,
  parameter int          Y_MAX       = 224,
  parameter int          X_INIT      = 160,
  parameter int          Y_INIT      = 112,
  parameter logic [7:0]  KEY_UP      = 8'h1A,
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_DOWN    = 8'h16,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  input  logic [7:0]     keycode,
  input  logic           blocked,
  output logic [1:0]     playerDir,
  output logic [X_W-1:0] posX,
  output logic [Y_W-1:0] posY,
  output logic           walking,
  output logic           step_done,
  output logic           walk_frame
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_WALK = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int OFF_W = $clog2(TILE_PX + 1);
  localparam int CNT_W = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

  localparam logic [OFF_W-1:0] TILE_OFF = OFF_W'(TILE_PX);
  localparam logic [OFF_W-1:0] STEP_OFF = OFF_W'(STEP_PX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_FRAMES - 1);

  // Targets are evaluated signed and two bits wider so that stepping off
  // either edge of the map yields an out-of-range value instead of wrapping.
  localparam logic signed [X_W+1:0] TILE_SX = (X_W+2)'(TILE_PX);
  localparam logic signed [Y_W+1:0] TILE_SY = (Y_W+2)'(TILE_PX);
  localparam logic signed [X_W+1:0] XMIN_S  = (X_W+2)'(X_MIN);
  localparam logic signed [X_W+1:0] XMAX_S  = (X_W+2)'(X_MAX);
  localparam logic signed [Y_W+1:0] YMIN_S  = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] YMAX_S  = (Y_W+2)'(Y_MAX);

  logic [1:0]       state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [X_W-1:0]   posx_q, posx_d;
  logic [Y_W-1:0]   posy_q, posy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             wf_q, wf_d;
  logic             sd_q, sd_d;
  logic             frame_clk_d_q, frame_clk_d_d;

  logic             tick;
  logic             key_valid;
  logic [1:0]       key_dir;
  logic             pass_ok;
  logic             legal_here;
  logic             legal_next;
  logic [X_W-1:0]   posx_step;
  logic [Y_W-1:0]   posy_step;

  function automatic logic in_bounds(input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y,
                                     input logic [1:0]     dir);
    logic signed [X_W+1:0] tx;
    logic signed [Y_W+1:0] ty;
    tx = $signed({2'b00, x});
    ty = $signed({2'b00, y});
    case (dir)
      DIR_UP:    ty = ty - TILE_SY;
      DIR_LEFT:  tx = tx - TILE_SX;
      DIR_DOWN:  ty = ty + TILE_SY;
      default:   tx = tx + TILE_SX;
    endcase
    in_bounds = (tx >= XMIN_S) && (tx <= XMAX_S) &&
                (ty >= YMIN_S) && (ty <= YMAX_S);
  endfunction

`ifdef PLAYER_COLLIDE_EN
  assign pass_ok = ~blocked;
`else
  logic unused_blocked;
  assign unused_blocked = blocked;
  assign pass_ok        = 1'b1;
`endif

  assign frame_clk_d_d = frame_clk;
  assign tick          = frame_clk & ~frame_clk_d_q;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    if (keycode == KEY_UP)         key_dir = DIR_UP;
    else if (keycode == KEY_LEFT)  key_dir = DIR_LEFT;
    else if (keycode == KEY_DOWN)  key_dir = DIR_DOWN;
    else if (keycode == KEY_RIGHT) key_dir = DIR_RIGHT;
    else                           key_valid = 1'b0;
  end

  always_comb begin
    posx_step = posx_q;
    posy_step = posy_q;
    case (dir_q)
      DIR_UP:    posy_step = posy_q - Y_W'(STEP_PX);
      DIR_LEFT:  posx_step = posx_q - X_W'(STEP_PX);
      DIR_DOWN:  posy_step = posy_q + Y_W'(STEP_PX);
      default:   posx_step = posx_q + X_W'(STEP_PX);
    endcase
  end

  // Decisions only ever concern the current facing: a differing key turns
  // instead of walking, so checking along dir_q is sufficient.
  assign legal_here = in_bounds(posx_q, posy_q, dir_q) & pass_ok;
  assign legal_next = in_bounds(posx_step, posy_step, dir_q) & pass_ok;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    wf_d    = wf_q;
    sd_d    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            if (key_dir != dir_q) begin
              dir_d   = key_dir;
              cnt_d   = '0;
              state_d = S_TURN;
            end else if (legal_here) begin
              off_d   = '0;
              state_d = S_WALK;
            end
          end
        end
        S_TURN: begin
          if (!key_valid) begin
            state_d = S_IDLE;
          end else if (key_dir != dir_q) begin
            dir_d = key_dir;
            cnt_d = '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (legal_here) begin
            off_d   = '0;
            state_d = S_WALK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WALK: begin
          posx_d = posx_step;
          posy_d = posy_step;
          off_d  = off_q + STEP_OFF;
          if (off_d == TILE_OFF) begin
            sd_d = 1'b1;
            wf_d = ~wf_q;
            // Chain directly into the next tile when the key is still held.
            if (key_valid && (key_dir == dir_q) && legal_next) begin
              off_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_DOWN;
      posx_q        <= X_W'(X_INIT);
      posy_q        <= Y_W'(Y_INIT);
      cnt_q         <= '0;
      off_q         <= '0;
      wf_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_clk_d_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      wf_q          <= wf_d;
      sd_q          <= sd_d;
      frame_clk_d_q <= frame_clk_d_d;
    end
  end

  assign playerDir  = dir_q;
  assign posX       = posx_q;
  assign posY       = posy_q;
  assign walking    = (state_q == S_WALK);
  assign step_done  = sd_q;
  assign walk_frame = wf_q;

endmodule

// File: tb/tb_player_walker.sv
// Scoreboard bench for player_walker: a behavioural model predicts the
// outputs of every frame tick; predictions are queued when the tick is driven
// and compared once the DUT has updated.
module tb_player_walker;

  localparam logic [7:0] K_UP    = 8'h1A;
  localparam logic [7:0] K_LEFT  = 8'h04;
  localparam logic [7:0] K_DOWN  = 8'h16;
  localparam logic [7:0] K_RIGHT = 8'h07;
  localparam logic [7:0] K_NONE  = 8'h00;

`ifdef PLAYER_COLLIDE_EN
  localparam bit COLLIDE = 1'b1;
`else
  localparam bit COLLIDE = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       blocked;
  logic [1:0] playerDir;
  logic [9:0] posX;
  logic [9:0] posY;
  logic       walking;
  logic       step_done;
  logic       walk_frame;

  player_walker dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .blocked    (blocked),
    .playerDir  (playerDir),
    .posX       (posX),
    .posY       (posY),
    .walking    (walking),
    .step_done  (step_done),
    .walk_frame (walk_frame)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int dir;
    int x;
    int y;
    int walk;
    int sd;
    int wf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // model state: 0 idle, 1 turn, 2 walk
  int m_state, m_dir, m_x, m_y, m_cnt, m_off, m_wf, m_sd;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic int key2dir(input logic [7:0] k);
    case (k)
      K_UP:    return 0;
      K_LEFT:  return 1;
      K_DOWN:  return 2;
      K_RIGHT: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_legal(input int x, input int y, input int dir,
                                 input bit blk);
    int nx, ny;
    nx = x;
    ny = y;
    case (dir)
      0: ny = ny - 16;
      1: nx = nx - 16;
      2: ny = ny + 16;
      default: nx = nx + 16;
    endcase
    return (nx >= 0) && (nx <= 304) && (ny >= 0) && (ny <= 224) &&
           !(COLLIDE && blk);
  endfunction

  task automatic model_reset();
    m_state = 0; m_dir = 2; m_x = 160; m_y = 112;
    m_cnt = 0; m_off = 0; m_wf = 0; m_sd = 0;
  endtask

  task automatic model_step(input int d, input bit blk);
    exp_t e;
    m_sd = 0;
    case (m_state)
      0: begin
        if (d >= 0) begin
          if (d != m_dir) begin
            m_dir = d; m_cnt = 0; m_state = 1;
          end else if (m_legal(m_x, m_y, m_dir, blk)) begin
            m_state = 2; m_off = 0;
          end
        end
      end
      1: begin
        if (d < 0) m_state = 0;
        else if (d != m_dir) begin m_dir = d; m_cnt = 0; end
        else if (m_cnt < 3) m_cnt++;
        else if (m_legal(m_x, m_y, m_dir, blk)) begin m_state = 2; m_off = 0; end
        else m_state = 0;
      end
      default: begin
        case (m_dir)
          0: m_y -= 2;
          1: m_x -= 2;
          2: m_y += 2;
          default: m_x += 2;
        endcase
        m_off += 2;
        if (m_off == 16) begin
          m_sd = 1;
          m_wf = 1 - m_wf;
          if (d == m_dir && m_legal(m_x, m_y, m_dir, blk)) m_off = 0;
          else m_state = 0;
        end
      end
    endcase
    e.dir = m_dir; e.x = m_x; e.y = m_y;
    e.walk = (m_state == 2) ? 1 : 0;
    e.sd = m_sd; e.wf = m_wf;
    sb_q.push_back(e);
  endtask

  // One frame: frame_clk rises, stays high for a second Clk (must not
  // re-trigger), then falls.
  task automatic do_tick(input logic [7:0] key, input logic blk);
    exp_t e;
    @(negedge Clk);
    keycode   = key;
    blocked   = blk;
    frame_clk = 1'b1;
    model_step(key2dir(key), blk);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check_eq("dir",  playerDir,  e.dir);
    check_eq("posX", posX,       e.x);
    check_eq("posY", posY,       e.y);
    check_eq("walk", walking,    e.walk);
    check_eq("sd",   step_done,  e.sd);
    check_eq("wf",   walk_frame, e.wf);
    @(posedge Clk);
    #1;
    check_eq("sd_hold", step_done, 0);
    check_eq("x_hold",  posX, e.x);
    check_eq("y_hold",  posY, e.y);
    @(negedge Clk);
    frame_clk = 1'b0;
    @(posedge Clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_dir"},  playerDir,  2);
    check_eq({tag, "_x"},    posX,       160);
    check_eq({tag, "_y"},    posY,       112);
    check_eq({tag, "_walk"}, walking,    0);
    check_eq({tag, "_sd"},   step_done,  0);
    check_eq({tag, "_wf"},   walk_frame, 0);
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    keycode   = K_NONE;
    blocked   = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("rst");
    @(negedge Clk);
    Reset = 1'b0;

    // Already facing down: walks at once, chained steps.
    for (int i = 1; i <= 20; i++) begin
      do_tick(K_DOWN, 1'b0);
      if (i == 9) begin
        check_eq("down_y1",  posY, 128);
        check_eq("down_wf1", walk_frame, 1);
      end
      if (i == 13) check_eq("down_y2", posY, 136);
    end
    // Release mid-step: the tile finishes, then idle.
    for (int i = 1; i <= 5; i++) do_tick(K_NONE, 1'b0);
    check_eq("rel_y",    posY, 160);
    check_eq("rel_walk", walking, 0);

    // Turn left, wait out the turn, walk one tile.
    for (int i = 1; i <= 13; i++) do_tick((i <= 12) ? K_LEFT : K_NONE, 1'b0);
    check_eq("left_x",    posX, 144);
    check_eq("left_walk", walking, 0);

    // Tap right: turn only.
    do_tick(K_RIGHT, 1'b0);
    do_tick(K_RIGHT, 1'b0);
    do_tick(K_NONE, 1'b0);
    check_eq("tap_dir", playerDir, 3);
    check_eq("tap_x",   posX, 144);

    // Walk part of a tile right, then reset mid-walk.
    for (int i = 1; i <= 4; i++) do_tick(K_RIGHT, 1'b0);
    check_eq("mid_x",    posX, 150);
    check_eq("mid_walk", walking, 1);
    @(negedge Clk);
    Reset     = 1'b1;
    frame_clk = 1'b1;
    keycode   = K_RIGHT;
    model_reset();
    @(posedge Clk);
    #1;
    check_reset_vals("midrst");
    @(negedge Clk);
    Reset     = 1'b0;
    frame_clk = 1'b0;
    keycode   = K_NONE;
    @(posedge Clk);

    // Walk up to the top edge and keep pushing against it.
    for (int i = 1; i <= 75; i++) begin
      do_tick(K_UP, 1'b0);
      if (i >= 62) begin
        check_eq("top_y",    posY, 0);
        check_eq("top_walk", walking, 0);
      end
    end
    check_eq("top_dir", playerDir, 0);

    // blocked asserted while turning and holding right.
    for (int i = 1; i <= 13; i++) do_tick((i <= 12) ? K_RIGHT : K_NONE, 1'b1);
    check_eq("blk_dir", playerDir, 3);
    check_eq("blk_x",   posX, COLLIDE ? 160 : 176);
    blocked = 1'b0;

    check_eq("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
